// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART command-frame to 32-bit bus initiator.
// Frames: 'W' + addr[4] + data[4] -> one bus write, reply 0x4B.
//         'R' + addr[4]           -> one bus read, reply data[4] MSB first.
//         anything else           -> reply 0x3F.
// Multi-byte fields are MSB first. A stalled frame is dropped silently
// after TIMEOUT_CYCLES idle cycles.
module uart_bus_bridge #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  output logic        rx_flag_clr,
  input  logic        uart_busy,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic        bus_wren,
  input  logic [31:0] bus_rddata,
  output logic        bridge_active
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RD_LAT  = 2'(READ_LATENCY);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ADDR       = 4'd1;
  localparam logic [3:0] S_DATA       = 4'd2;
  localparam logic [3:0] S_BUS_WR     = 4'd3;
  localparam logic [3:0] S_BUS_RD     = 4'd4;
  localparam logic [3:0] S_RD_WAIT    = 4'd5;
  localparam logic [3:0] S_TX_LOAD    = 4'd6;
  localparam logic [3:0] S_TX_PULSE   = 4'd7;
  localparam logic [3:0] S_TX_WAIT_HI = 4'd8;
  localparam logic [3:0] S_TX_WAIT_LO = 4'd9;

  // States during which the bridge owns the bus.
  function automatic logic is_bus_state(input logic [3:0] s);
    return (s == S_BUS_WR) || (s == S_BUS_RD) || (s == S_RD_WAIT);
  endfunction

  logic [3:0]    state_q, state_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    lat_q, lat_d;
  logic [31:0]   txsh_q, txsh_d;
  logic [2:0]    rem_q, rem_d;
  logic [1:0]    guard_q, guard_d;
  logic          clr_prev_q, clr_prev_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wrdata_q, bus_wrdata_d;
  logic          bus_wren_q, bus_wren_d;
  logic          active_q, active_d;
  logic          rx_state_s;
  logic          consume_s;

  // Byte intake: only in receiving states, and never two cycles in a row so
  // the UART has a cycle to drop rx_flag after the clear pulse.
  always_comb begin
    rx_state_s = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    consume_s  = rx_flag & rx_state_s & ~clr_prev_q & ~rst;
  end

  // Next-state and datapath computation for the frame/bus/reply sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    to_d       = to_q;
    lat_d      = lat_q;
    txsh_d     = txsh_q;
    rem_d      = rem_q;
    guard_d    = guard_q;
    tx_data_d  = tx_data_q;
    clr_prev_d = consume_s;

    case (state_q)
      S_IDLE: begin
        if (consume_s) begin
          cnt_d  = 2'd0;
          to_d   = '0;
          addr_d = 32'h0;
          data_d = 32'h0;
          if (rx_data == 8'h57) begin
            cmd_wr_d = 1'b1;
            state_d  = S_ADDR;
          end else if (rx_data == 8'h52) begin
            cmd_wr_d = 1'b0;
            state_d  = S_ADDR;
          end else begin
            txsh_d  = {8'h3F, 24'h0};
            rem_d   = 3'd1;
            state_d = S_TX_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (consume_s) begin
          addr_d = {addr_q[23:0], rx_data};
          to_d   = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = cmd_wr_q ? S_DATA : S_BUS_RD;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (to_q == TO_LAST) begin
          // Host went quiet mid-frame: drop everything collected so far.
          to_d    = '0;
          cnt_d   = 2'd0;
          addr_d  = 32'h0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_DATA: begin
        if (consume_s) begin
          data_d = {data_q[23:0], rx_data};
          to_d   = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_BUS_WR;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          cnt_d   = 2'd0;
          addr_d  = 32'h0;
          data_d  = 32'h0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_BUS_WR: begin
        txsh_d  = {8'h4B, 24'h0};
        rem_d   = 3'd1;
        state_d = S_TX_LOAD;
      end
      S_BUS_RD: begin
        if (RD_LAT == 2'd0) begin
          txsh_d  = bus_rddata;
          rem_d   = 3'd4;
          state_d = S_TX_LOAD;
        end else begin
          lat_d   = 2'd1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == RD_LAT) begin
          txsh_d  = bus_rddata;
          rem_d   = 3'd4;
          state_d = S_TX_LOAD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_TX_LOAD: begin
        if (!uart_busy) begin
          tx_data_d = txsh_q[31:24];
          txsh_d    = {txsh_q[23:0], 8'h00};
          state_d   = S_TX_PULSE;
        end else begin
          state_d = S_TX_LOAD;
        end
      end
      S_TX_PULSE: begin
        guard_d = 2'd0;
        state_d = S_TX_WAIT_HI;
      end
      S_TX_WAIT_HI: begin
        // A UART that never raises busy must not hang the bridge.
        if (uart_busy || (guard_q == 2'd3)) begin
          state_d = S_TX_WAIT_LO;
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end
      S_TX_WAIT_LO: begin
        if (!uart_busy) begin
          rem_d   = rem_q - 3'd1;
          state_d = (rem_q <= 3'd1) ? S_IDLE : S_TX_LOAD;
        end else begin
          state_d = S_TX_WAIT_LO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus and TX outputs are registered from the next state so they line up
    // exactly with the state that owns them.
    active_d     = is_bus_state(state_d);
    bus_addr_d   = active_d ? addr_d : 32'h0;
    bus_wrdata_d = (state_d == S_BUS_WR) ? data_d : 32'h0;
    bus_wren_d   = (state_d == S_BUS_WR);
    tx_send_d    = (state_d == S_TX_PULSE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_wr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      to_q         <= '0;
      lat_q        <= 2'd0;
      txsh_q       <= 32'h0;
      rem_q        <= 3'd0;
      guard_q      <= 2'd0;
      clr_prev_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_send_q    <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wrdata_q <= 32'h0;
      bus_wren_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_wr_q     <= cmd_wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      to_q         <= to_d;
      lat_q        <= lat_d;
      txsh_q       <= txsh_d;
      rem_q        <= rem_d;
      guard_q      <= guard_d;
      clr_prev_q   <= clr_prev_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      bus_addr_q   <= bus_addr_d;
      bus_wrdata_q <= bus_wrdata_d;
      bus_wren_q   <= bus_wren_d;
      active_q     <= active_d;
    end
  end

  // Clear pulse accompanies the capture edge; the write strobe is also
  // suppressed in the reset cycle itself so a reset never completes a write.
  assign rx_flag_clr   = consume_s;
  assign tx_send       = tx_send_q;
  assign tx_data       = tx_data_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wrdata    = bus_wrdata_q;
  assign bus_wren      = bus_wren_q & ~rst;
  assign bridge_active = active_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: UART rx/tx models, a delayed-read
// bus model, table vectors, hand-written corner sequences and random frames.
module tb_uart_bus_bridge;

  localparam int RL = 1;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_flag = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_flag_clr;
  logic        uart_busy = 1'b0;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic [31:0] bus_rddata = 32'h0;
  logic        bridge_active;

  uart_bus_bridge #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_flag(rx_flag), .rx_data(rx_data), .rx_flag_clr(rx_flag_clr),
    .uart_busy(uart_busy), .tx_send(tx_send), .tx_data(tx_data),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wren(bus_wren),
    .bus_rddata(bus_rddata), .bridge_active(bridge_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } bus_op_t;
  typedef struct { int len; int nrep; } frame_t;
  typedef struct {
    logic [71:0] fr; int n; bit has_bus; bit wr;
    logic [31:0] addr; logic [31:0] data; logic [31:0] reply; int nrep;
  } vec_t;

  bus_op_t    exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rxq[$];
  frame_t     frames[$];
  logic [31:0] rd_key = 32'h0;

  // Negedge samples shared with the posedge models
  logic        pop_evt = 1'b0, send_evt = 1'b0, samp_act = 1'b0;
  logic [31:0] samp_addr = 32'h0;
  logic        act_prev = 1'b0, wren_prev = 1'b0, clr_prev = 1'b0;
  logic [7:0]  tx_latched = 8'h00;
  int cur_left = 0, cur_rep = 0, rep_left = 0;
  int tx_total = 0, bus_total = 0;
  frame_t  mf;
  bus_op_t mb;
  int busy_cnt = 0;

  // Monitor: samples and checks all DUT outputs away from the active edge
  always @(negedge clk) begin
    pop_evt   = rx_flag_clr;
    send_evt  = tx_send;
    samp_act  = bridge_active;
    samp_addr = bus_addr;
    if (!rst) begin
      if (rx_flag_clr) begin
        chk("clr_consecutive", {31'd0, clr_prev}, 32'd0);
        chk("clr_during_reply", {31'd0, (rep_left > 0) || uart_busy}, 32'd0);
        if (cur_left == 0) begin
          n_cmp++;
          if (frames.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_consume: byte %h consumed, no frame pending", rx_data);
          end else begin
            mf = frames.pop_front();
            cur_left = mf.len;
            cur_rep  = mf.nrep;
          end
        end
        if (cur_left > 0) begin
          cur_left--;
          if (cur_left == 0) rep_left = cur_rep;
        end
      end
      if (tx_send) begin
        chk("tx_send_while_busy", {31'd0, uart_busy}, 32'd0);
        tx_total++;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tx: got byte %h, required no transmission", tx_data);
        end else begin
          n_cmp--;
          chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
        tx_latched = tx_data;
        if (rep_left > 0) rep_left--;
      end
      if (uart_busy) chk("tx_data_stable", {24'd0, tx_data}, {24'd0, tx_latched});
      if (!bridge_active) begin
        chk("bus_addr_idle", bus_addr, 32'd0);
        chk("bus_wrdata_idle", bus_wrdata, 32'd0);
        chk("bus_wren_idle", {31'd0, bus_wren}, 32'd0);
      end else if (!act_prev) begin
        bus_total++;
        n_cmp++;
        if (exp_bus.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_bus: addr %h wren %0d, required no access", bus_addr, bus_wren);
        end else begin
          n_cmp--;
          mb = exp_bus.pop_front();
          chk("bus_kind_wren", {31'd0, bus_wren}, {31'd0, mb.wr});
          chk("bus_addr", bus_addr, mb.addr);
          if (mb.wr) chk("bus_wrdata", bus_wrdata, mb.data);
        end
      end
      if (bus_wren) chk("wren_single_cycle", {31'd0, wren_prev}, 32'd0);
    end
    clr_prev  = rx_flag_clr;
    act_prev  = bridge_active;
    wren_prev = bus_wren;
  end

  // UART receive side: present queued bytes, drop the head when cleared
  always @(posedge clk) begin
    #1;
    if (pop_evt && rxq.size() > 0) rxq.delete(0);
    rx_flag = (rxq.size() > 0);
    rx_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // UART transmit side: busy for a few cycles per send, sometimes never busy
  always @(posedge clk) begin
    #1;
    if (send_evt) begin
      if ($urandom_range(0, 7) == 0) busy_cnt = 0;
      else busy_cnt = $urandom_range(2, 6);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_busy = (busy_cnt > 0);
  end

  // Bus slave: read data valid RL(=1) cycle after the address is presented
  always @(posedge clk) begin
    #1;
    bus_rddata = samp_act ? (samp_addr ^ rd_key) : 32'h0;
  end

  function automatic vec_t mk_w(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.fr = {8'h57, a, d}; v.n = 9; v.has_bus = 1'b1; v.wr = 1'b1;
    v.addr = a; v.data = d; v.reply = {8'h4B, 24'h0}; v.nrep = 1;
    return v;
  endfunction

  function automatic vec_t mk_r(input logic [31:0] a, input logic [31:0] rd);
    vec_t v;
    v.fr = {8'h52, a, 32'h0}; v.n = 5; v.has_bus = 1'b1; v.wr = 1'b0;
    v.addr = a; v.data = rd; v.reply = rd; v.nrep = 4;
    return v;
  endfunction

  function automatic vec_t mk_bad(input logic [7:0] b);
    vec_t v;
    v.fr = {b, 64'h0}; v.n = 1; v.has_bus = 1'b0; v.wr = 1'b0;
    v.addr = 32'h0; v.data = 32'h0; v.reply = {8'h3F, 24'h0}; v.nrep = 1;
    return v;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    rxq.push_back(b);
  endtask

  task automatic apply_vec(input vec_t v, input int gapmax);
    bus_op_t op;
    if (v.has_bus && !v.wr) rd_key = v.addr ^ v.data;
    if (v.has_bus) begin
      op.wr = v.wr; op.addr = v.addr; op.data = v.data;
      exp_bus.push_back(op);
    end
    for (int i = 0; i < v.nrep; i++) exp_tx.push_back(v.reply[31 - 8*i -: 8]);
    frames.push_back('{v.n, v.nrep});
    for (int i = 0; i < v.n; i++) begin
      repeat ($urandom_range(0, gapmax)) @(posedge clk);
      push_byte(v.fr[71 - 8*i -: 8]);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 1000 && (rxq.size() != 0 || exp_tx.size() != 0 || exp_bus.size() != 0
                        || uart_busy || bridge_active)) begin
      @(posedge clk);
      t++;
    end
    chk("idle_reached_in_budget", {31'd0, t < 1000}, 32'd1);
    if (t >= 1000) begin
      exp_tx.delete(); exp_bus.delete(); frames.delete(); rxq.delete();
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rx_flag_clr"}, {31'd0, rx_flag_clr}, 32'd0);
    chk({tag, "_tx_send"}, {31'd0, tx_send}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wrdata"}, bus_wrdata, 32'd0);
    chk({tag, "_bus_wren"}, {31'd0, bus_wren}, 32'd0);
    chk({tag, "_bridge_active"}, {31'd0, bridge_active}, 32'd0);
  endtask

  vec_t vt[6];

  initial begin
    int tx0, bus0, typ;
    logic [7:0]  b;
    logic [31:0] a, d;

    vt[0] = mk_w(32'h0000_1004, 32'hDEAD_BEEF);
    vt[1] = mk_r(32'h0000_1004, 32'h1234_5678);
    vt[2] = mk_bad(8'h41);
    vt[3] = mk_w(32'h0000_0003, 32'hCAFE_F00D);
    vt[4] = mk_r(32'hFFFF_FFFF, 32'h0000_0000);
    vt[5] = mk_w(32'hFFFF_FFFC, 32'h0000_0001);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      apply_vec(vt[i], 2);
      wait_idle();
    end

    // Timeout: partial 'W' frame then a long stall, then a normal read
    tx0 = tx_total;
    bus0 = bus_total;
    frames.push_back('{3, 0});
    push_byte(8'h57); push_byte(8'h00); push_byte(8'h00);
    for (int t = 0; t < 200 && rxq.size() != 0; t++) @(posedge clk);
    repeat (130) @(posedge clk);
    chk("timeout_no_reply", tx_total, tx0);
    chk("timeout_no_bus", bus_total, bus0);
    apply_vec(mk_r(32'h0000_2000, 32'hA5A5_0F0F), 0);
    wait_idle();

    // Back-pressure: next frame queued while the 4-byte reply is in progress
    apply_vec(mk_r(32'h0000_1004, 32'h1234_5678), 0);
    apply_vec(mk_w(32'h0000_0040, 32'h0BAD_F00D), 0);
    wait_idle();

    // Reset after 6 bytes of a 'W' frame
    frames.push_back('{6, 0});
    push_byte(8'h57); push_byte(8'h00); push_byte(8'h00);
    push_byte(8'h10); push_byte(8'h04); push_byte(8'hDE);
    for (int t = 0; t < 200 && rxq.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midframe_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    apply_vec(mk_w(32'h0000_1008, 32'h1357_9BDF), 1);
    wait_idle();

    // Random frames against the frame-level reference model
    rd_key = $urandom;
    for (int k = 0; k < 40; k++) begin
      typ = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      if (typ == 0) begin
        apply_vec(mk_w(a, d), 4);
      end else if (typ == 1) begin
        apply_vec(mk_r(a, a ^ rd_key), 4);
      end else begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        apply_vec(mk_bad(b), 4);
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    chk("end_exp_tx_empty", exp_tx.size(), 32'd0);
    chk("end_exp_bus_empty", exp_bus.size(), 32'd0);
    chk("end_rx_queue_empty", rxq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug/loader bus initiator. It sits between the UART_duplex receive/transmit handshake and the memory_controller bus, on the other end of both.
- It receives command frames from a host over UART and issues single 32-bit bus writes or reads, answering over UART.
- While a bus access is in flight it asserts bridge_active. The top level uses this signal to mux its bus outputs ahead of the core's.

Parameters:
- READ_LATENCY, 1, cycles from bus_addr presentation to valid bus_rddata (legal range 0..3).
- TIMEOUT_CYCLES, 50_000_000, maximum idle cycles allowed between bytes of one frame before the frame is aborted.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rx_flag  in  1  UART has a received byte pending
- rx_data  in  8  received byte; valid while rx_flag=1
- rx_flag_clr  out  1  one-cycle pulse; consumes the pending byte
- uart_busy  in  1  UART transmitter busy
- tx_send  out  1  one-cycle pulse; starts transmission of tx_data
- tx_data  out  8  byte to transmit; held stable from tx_send until uart_busy falls
- bus_addr  out  32  bus address
- bus_wrdata  out  32  bus write data
- bus_wren  out  1  bus write strobe, exactly one cycle per write
- bus_rddata  in  32  bus read data
- bridge_active  out  1  high during BUS_WR, BUS_RD and RD_WAIT

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Byte intake:
  - In any receiving state, rx_flag=1 → capture rx_data and pulse rx_flag_clr in the same cycle.
  - At most one byte is consumed per 2 cycles; rx_flag_clr is never high on two consecutive cycles.
- Frame formats (multi-byte fields are MSB first):
  - 'W' (0x57) + addr[4] + data[4] → one bus write → reply 0x4B.
  - 'R' (0x52) + addr[4] → one bus read → reply data[4], MSB first.
  - Any other first byte → reply 0x3F, then return to IDLE.
- FSM states: IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, TX_LOAD, TX_PULSE, TX_WAIT_HI, TX_WAIT_LO.
- Transitions:
  - IDLE → ADDR on byte 0x57 or 0x52, latching the command type.
  - ADDR: byte counter counts 4 bytes, shifting into addr_reg. After the 4th byte: W → DATA, R → BUS_RD.
  - DATA: 4 bytes shift into data_reg, then → BUS_WR.
  - BUS_WR (1 cycle): drive bus_addr/bus_wrdata and set bus_wren=1; load reply 0x4B (count 1); → TX_LOAD.
  - BUS_RD: drive bus_addr and wait READ_LATENCY cycles in RD_WAIT (held for the whole access). Then sample bus_rddata into a shift register (count 4) and → TX_LOAD. With READ_LATENCY=0, sample in the BUS_RD cycle itself.
  - TX_LOAD: wait for uart_busy=0, place the next byte on tx_data, → TX_PULSE.
  - TX_PULSE: tx_send=1 for 1 cycle → TX_WAIT_HI.
  - TX_WAIT_HI: wait for uart_busy=1, guarded to 4 cycles. If the guard expires, treat the byte as sent.
  - TX_WAIT_LO: wait for uart_busy=0, then decrement the remaining count. Remaining >0 → TX_LOAD; remaining =0 → IDLE.
- Timeout:
  - In ADDR/DATA, a counter resets on every consumed byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES → IDLE with no reply and no bus access. Partial fields are discarded.
- Bytes arriving during bus or TX states are not consumed: rx_flag_clr stays 0 and the byte waits in the UART.
- bus_addr and bus_wrdata are 0 outside BUS_WR/BUS_RD/RD_WAIT. No bus activity occurs outside those states.
- No address alignment check: the 32-bit address is passed through unchanged.
- Reset mid-operation: an immediate return to reset values. Any in-flight reply is abandoned; no partial bus write occurs, since bus_wren is forced to 0 in the reset cycle.

Test Plan:
- Write: bytes 57 00 00 10 04 DE AD BE EF → exactly one cycle with bus_wren=1, bus_addr=0x00001004, bus_wrdata=0xDEADBEEF; then one tx_send carrying 0x4B.
- Read at READ_LATENCY=1: bytes 52 00 00 10 04 with bus_rddata=0x12345678 → bus_wren stays 0; tx bytes 12,34,56,78 in order, each tx_send issued only after uart_busy falls.
- Bad command: byte 0x41 → no bus access; single tx byte 0x3F; FSM back in IDLE.
- Timeout at TIMEOUT_CYCLES=100: send 57 00 00 then stall 100 cycles → no reply, no bus_wren. A following full 'R' frame is then handled normally.
- Back-pressure: hold rx_flag=1 continuously with a new byte every 2 cycles during a 4-byte read reply → rx_flag_clr stays 0 until the FSM reaches IDLE. No byte is lost; the next frame is parsed correctly.
- Reset mid-frame: assert rst after 6 bytes of a 'W' frame → all outputs 0 next cycle; no bus_wren; a new complete frame then succeeds.
